// File: rtl/sipo_pkg.sv
// Shared types and constants for the SIPO deserializer.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

  localparam int unsigned SIPO_DEFAULT_DATA_WIDTH = 8;

  // Width needed to count 0..width inclusive.
  function automatic int unsigned sipo_count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_output_holding_register.sv
// Valid/ready output holding register: loads completed words, flags drops.
module sipo_output_holding_register #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  overrun_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  // Load when empty or draining this edge; otherwise a new word is dropped.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (load_valid_i) begin
      if (!valid_q || ready_i) begin
        data_d  = load_data_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Register the holding state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sipo_deserializer_8_bit.sv
// Framed serial-in/parallel-out receiver with valid/ready output register.
module sipo_deserializer_8_bit
  import sipo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SIPO_DEFAULT_DATA_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                               Clk_In,
  input  logic                               Reset_In,
  input  logic                               Serial_Valid_In,
  input  logic                               Serial_Data_In,
  input  logic                               Frame_Start_In,
  input  logic                               Parallel_Ready_In,
  output logic [DATA_WIDTH-1:0]              Parallel_Data_Out,
  output logic                               Parallel_Valid_Out,
  output logic [$clog2(DATA_WIDTH+1)-1:0]    Bit_Count_Out,
  output logic                               Overrun_Error_Out,
  output logic                               Frame_Error_Out,
  output logic [DATA_WIDTH-1:0]              SIPO_Shift_Register
);

  localparam int unsigned CW = sipo_count_width(DATA_WIDTH);

  sipo_state_t           state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  frame_err_q, frame_err_d;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  word_done;

  // Next-state: framing, counting and shifting of qualified bits.
  always_comb begin
    shifted     = MSB_FIRST ? {shreg_q[DATA_WIDTH-2:0], Serial_Data_In}
                            : {Serial_Data_In, shreg_q[DATA_WIDTH-1:1]};
    state_d     = state_q;
    count_d     = count_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;
    if (Serial_Valid_In) begin
      case (state_q)
        IDLE: begin
          if (Frame_Start_In) begin
            shreg_d = shifted;
            count_d = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          shreg_d = shifted;
          // A start strobe wins over completion: the word in flight is aborted.
          if (Frame_Start_In) begin
            frame_err_d = 1'b1;
            count_d     = CW'(1);
          end else if (count_q == CW'(DATA_WIDTH - 1)) begin
            word_done = 1'b1;
            count_d   = '0;
            state_d   = IDLE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
    end
  end

  sipo_output_holding_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk          (Clk_In),
    .rst          (Reset_In),
    .load_valid_i (word_done),
    .load_data_i  (shifted),
    .ready_i      (Parallel_Ready_In),
    .data_o       (Parallel_Data_Out),
    .valid_o      (Parallel_Valid_Out),
    .overrun_o    (Overrun_Error_Out)
  );

  assign Bit_Count_Out       = count_q;
  assign Frame_Error_Out     = frame_err_q;
  assign SIPO_Shift_Register = shreg_q;

endmodule

// File: tb/tb_sipo_deserializer_8_bit.sv
// Bench for sipo_deserializer_8_bit: MSB-first and LSB-first instances share stimulus.
module tb_sipo_deserializer_8_bit;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0, sv = 1'b0, sd = 1'b0, fs = 1'b0, rdy = 1'b0;

  logic [7:0] m_data, l_data, m_sh, l_sh;
  logic       m_valid, l_valid, m_ovr, l_ovr, m_ferr, l_ferr;
  logic [3:0] m_cnt, l_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sipo_deserializer_8_bit #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .Clk_In(clk), .Reset_In(rst), .Serial_Valid_In(sv), .Serial_Data_In(sd),
    .Frame_Start_In(fs), .Parallel_Ready_In(rdy), .Parallel_Data_Out(m_data),
    .Parallel_Valid_Out(m_valid), .Bit_Count_Out(m_cnt), .Overrun_Error_Out(m_ovr),
    .Frame_Error_Out(m_ferr), .SIPO_Shift_Register(m_sh));

  sipo_deserializer_8_bit #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .Clk_In(clk), .Reset_In(rst), .Serial_Valid_In(sv), .Serial_Data_In(sd),
    .Frame_Start_In(fs), .Parallel_Ready_In(rdy), .Parallel_Data_Out(l_data),
    .Parallel_Valid_Out(l_valid), .Bit_Count_Out(l_cnt), .Overrun_Error_Out(l_ovr),
    .Frame_Error_Out(l_ferr), .SIPO_Shift_Register(l_sh));

  // Reference model: history of shifted bits, bits in current frame, output slot.
  bit         hist[$];
  int         e_cnt = 0;
  bit         e_active = 0;
  bit         e_valid = 0, e_ovr = 0, e_ferr = 0;
  logic [7:0] e_data[2] = '{8'h00, 8'h00};

  // Last W shifted bits packed: k=0 newest at bit 0, k=1 newest at bit W-1.
  function automatic logic [7:0] shm(input int k);
    logic [7:0] r;
    int n;
    r = '0;
    n = hist.size();
    for (int j = 0; j < n && j < W; j++) begin
      if (k == 0) r[j] = hist[n-1-j];
      else        r[W-1-j] = hist[n-1-j];
    end
    return r;
  endfunction

  function automatic logic [22:0] obs(input int k);
    if (k == 0) return {m_valid, m_data, m_cnt, m_ovr, m_ferr, m_sh};
    return {l_valid, l_data, l_cnt, l_ovr, l_ferr, l_sh};
  endfunction

  function automatic logic [22:0] expv(input int k);
    return {e_valid, e_data[k], 4'(e_cnt), e_ovr, e_ferr, shm(k)};
  endfunction

  task automatic model_edge(input bit v, input bit d, input bit s, input bit r, input bit rs);
    bit old_valid, done;
    if (rs) begin
      hist.delete();
      e_cnt = 0; e_active = 0; e_valid = 0; e_ovr = 0; e_ferr = 0;
      e_data[0] = '0; e_data[1] = '0;
      return;
    end
    old_valid = e_valid;
    e_ovr = 0; e_ferr = 0; done = 0;
    if (v && s) begin
      if (e_active) e_ferr = 1;
      hist.push_back(d);
      e_cnt = 1; e_active = 1;
    end else if (v && e_active) begin
      hist.push_back(d);
      e_cnt++;
      if (e_cnt == W) begin
        done = 1; e_cnt = 0; e_active = 0;
      end
    end
    if (hist.size() > W) void'(hist.pop_front());
    if (old_valid && r) e_valid = 0;
    if (done) begin
      if (!old_valid || r) begin
        e_data[0] = shm(0); e_data[1] = shm(1); e_valid = 1;
      end else begin
        e_ovr = 1;
      end
    end
  endtask

  task automatic step(input bit v, input bit d, input bit s, input bit r, input bit rs);
    sv = v; sd = d; fs = s; rdy = r; rst = rs;
    @(posedge clk);
    model_edge(v, d, s, r, rs);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== 23'd0) begin
        bad++; $display("FAIL reset[%0d] got=%h exp=%h", k, obs(k), 23'd0);
      end
    end
  endtask

  task automatic test_msb_word();
    logic [7:0] w;
    w = 8'hA5;
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, w[7-i], i == 0, 1, 0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv(k)) begin
          bad++; $display("FAIL msb_word[%0d] bit=%0d got=%h exp=%h", k, i, obs(k), expv(k));
        end
      end
      if (i == 6) begin
        total++;
        if (m_valid !== 1'b0) begin
          bad++; $display("FAIL msb_early_valid got=%b exp=0", m_valid);
        end
      end
    end
    total++;
    if ({m_valid, m_data} !== {1'b1, 8'hA5}) begin
      bad++; $display("FAIL msb_a5 got=%b/%h exp=1/a5", m_valid, m_data);
    end
    step(0, 0, 0, 1, 0);
    total++;
    if (m_valid !== 1'b0) begin
      bad++; $display("FAIL msb_one_cycle got=%b exp=0", m_valid);
    end
  endtask

  task automatic test_gap();
    logic [7:0] w;
    w = 8'h3C;
    for (int i = 0; i < 11; i++) begin
      if (i >= 4 && i < 7) step(0, 1, 1, 1, 0);
      else step(1, w[7 - (i < 4 ? i : i - 3)], i == 0, 1, 0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv(k)) begin
          bad++; $display("FAIL gap[%0d] step=%0d got=%h exp=%h", k, i, obs(k), expv(k));
        end
      end
      if (i >= 4 && i < 7) begin
        total++;
        if (m_cnt !== 4'd4) begin
          bad++; $display("FAIL gap_hold step=%0d got=%0d exp=4", i, m_cnt);
        end
      end
    end
    total++;
    if ({m_valid, m_data} !== {1'b1, 8'h3C}) begin
      bad++; $display("FAIL gap_word got=%b/%h exp=1/3c", m_valid, m_data);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] w;
    int ovr_seen;
    w = 16'h1122;
    ovr_seen = 0;
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, w[15-i], (i % 8) == 0, 0, 0);
      if (m_ovr === 1'b1) ovr_seen++;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv(k)) begin
          bad++; $display("FAIL overrun[%0d] bit=%0d got=%h exp=%h", k, i, obs(k), expv(k));
        end
      end
    end
    total++;
    if ({m_valid, m_data, m_ovr} !== {1'b1, 8'h11, 1'b1} || ovr_seen != 1) begin
      bad++; $display("FAIL overrun_hold got=%b/%h/%b pulses=%0d exp=1/11/1 pulses=1",
                      m_valid, m_data, m_ovr, ovr_seen);
    end
    step(0, 0, 0, 1, 0);
    total++;
    if ({m_valid, m_ovr} !== 2'b00) begin
      bad++; $display("FAIL overrun_drain got=%b/%b exp=0/0", m_valid, m_ovr);
    end
  endtask

  task automatic test_restart();
    logic [12:0] w;
    int fe_seen, ov_seen;
    w = {5'($urandom), 8'hC3};
    fe_seen = 0; ov_seen = 0;
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 13; i++) begin
      step(1, w[12-i], i == 0 || i == 5, 1, 0);
      if (m_ferr === 1'b1) fe_seen++;
      if (m_ovr === 1'b1) ov_seen++;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv(k)) begin
          bad++; $display("FAIL restart[%0d] bit=%0d got=%h exp=%h", k, i, obs(k), expv(k));
        end
      end
    end
    total++;
    if ({m_valid, m_data} !== {1'b1, 8'hC3} || fe_seen != 1 || ov_seen != 0) begin
      bad++; $display("FAIL restart_word got=%b/%h ferr=%0d ovr=%0d exp=1/c3 ferr=1 ovr=0",
                      m_valid, m_data, fe_seen, ov_seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    w = 8'h5A;
    for (int i = 0; i < 4; i++) step(1, w[7-i], i == 0, 1, 0);
    step(1, 1, 0, 1, 1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== 23'd0) begin
        bad++; $display("FAIL reset_mid[%0d] got=%h exp=%h", k, obs(k), 23'd0);
      end
    end
    for (int i = 0; i < 8; i++) step(1, w[7-i], i == 0, 1, 0);
    total++;
    if ({m_valid, m_data, m_sh} !== {1'b1, 8'h5A, 8'h5A}) begin
      bad++; $display("FAIL reset_mid_word got=%b/%h/%h exp=1/5a/5a", m_valid, m_data, m_sh);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    w = {8'hE1, 8'h1E};
    for (int i = 0; i < 16; i++) begin
      step(1, w[i], (i % 8) == 0, 1, 0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv(k)) begin
          bad++; $display("FAIL b2b[%0d] bit=%0d got=%h exp=%h", k, i, obs(k), expv(k));
        end
      end
      if (i == 7 || i == 15) begin
        total++;
        if ({l_valid, l_data} !== {1'b1, (i == 7) ? 8'h1E : 8'hE1}) begin
          bad++; $display("FAIL b2b_word bit=%0d got=%b/%h exp=1/%h", i, l_valid, l_data,
                          (i == 7) ? 8'h1E : 8'hE1);
        end
      end
    end
  endtask

  task automatic test_random();
    bit v, d, s, r, rs;
    for (int i = 0; i < 1500; i++) begin
      v  = $urandom_range(0, 3) != 0;
      d  = 1'($urandom);
      s  = e_active ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, 2) != 0;
      rs = $urandom_range(0, 199) == 0;
      step(v, d, s, r, rs);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv(k)) begin
          bad++; $display("FAIL random[%0d] cyc=%0d got=%h exp=%h", k, i, obs(k), expv(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_word();
    test_gap();
    test_overrun();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
